// File: rtl/dram_pkg.sv
// Shared types for the DRAM behavioural model.
//   bank_state_e : per-bank FSM states
//   cmd_e        : decoded command on the pins for the current cycle
//   decode_cmd   : pin-level strobes -> cmd_e
package dram_pkg;

  typedef enum logic [1:0] {IDLE, OPENING, ACTIVE, CLOSING} bank_state_e;
  typedef enum logic [2:0] {NOP, ACT, READ, WRITE, PRE} cmd_e;

  // we_none is the AND of all WEn bits: READ when no byte is enabled.
  function automatic cmd_e decode_cmd(input logic csn, input logic rasn,
                                      input logic casn, input logic we_none);
    cmd_e c;
    c = NOP;
    if (!csn) begin
      case ({rasn, casn})
        2'b01:   c = ACT;
        2'b10:   c = we_none ? READ : WRITE;
        2'b00:   c = PRE;
        default: c = NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/dram_bank_fsm.sv
// One DRAM bank: state machine, tRCD/tRP timer and open-row register.
//   clk, rst  : clock, async active-high reset
//   sel       : this bank is addressed by the current command
//   cmd       : decoded command (cmd_e encoding)
//   row       : row address, latched on a legal ACT
//   legal     : cmd would be legal for this bank in its current state
//   open_row  : row latched by the last ACT
module dram_bank_fsm
  import dram_pkg::*;
#(
  parameter int ROW_W = 11,
  parameter int T_RCD = 5,
  parameter int T_RP  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [2:0]       cmd,
  input  logic [ROW_W-1:0] row,
  output logic             legal,
  output logic [ROW_W-1:0] open_row
);

  localparam int TMAX  = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int TMR_W = (TMAX > 2) ? $clog2(TMAX) : 1;
  // The state change itself takes one edge, so the timer starts at T-2:
  // an ACT sampled at edge n leaves ACTIVE visible to the command at n+T_RCD.
  localparam logic [TMR_W-1:0] RCD_LD = TMR_W'((T_RCD > 1) ? T_RCD - 2 : 0);
  localparam logic [TMR_W-1:0] RP_LD  = TMR_W'((T_RP  > 1) ? T_RP  - 2 : 0);

  bank_state_e      state, state_nx;
  logic [TMR_W-1:0] tmr, tmr_nx;
  cmd_e             c;

  assign c = cmd_e'(cmd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tmr      <= '0;
      open_row <= '0;
    end else begin
      state <= state_nx;
      tmr   <= tmr_nx;
      if (sel && c == ACT && state == IDLE) open_row <= row;
    end
  end

  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    case (state)
      IDLE:
        if (sel && c == ACT) begin
          state_nx = (T_RCD == 1) ? ACTIVE : OPENING;
          tmr_nx   = RCD_LD;
        end
      OPENING:
        if (tmr == '0) state_nx = ACTIVE;
        else           tmr_nx   = tmr - 1'b1;
      ACTIVE:
        if (sel && c == PRE) begin
          state_nx = (T_RP == 1) ? IDLE : CLOSING;
          tmr_nx   = RP_LD;
        end
      CLOSING:
        if (tmr == '0) state_nx = IDLE;
        else           tmr_nx   = tmr - 1'b1;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    legal = 1'b1;
    case (c)
      ACT:               legal = (state == IDLE);
      READ, WRITE, PRE:  legal = (state == ACTIVE);
      default:           legal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dram_model_mb.sv
// Cycle-level multi-bank SDRAM model with protocol checking.
//   clk, rst          : clock, async active-high reset
//   CSn/RASn/CASn/WEn : command strobes (WEn is per-byte, active-low)
//   BA, A             : bank address; row (ACT) or column A[COL_W-1:0]
//   D                 : write data
//   Q, VALID          : read data, one-cycle strobe T_CL cycles after READ
//   err               : sticky flag, set by any illegal command
module dram_model_mb
  import dram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ROW_W  = 11,
  parameter int COL_W  = 10,
  parameter int BANKS  = 1,
  parameter int T_RCD  = 5,
  parameter int T_CL   = 5,
  parameter int T_RP   = 5,
  localparam int BA_W  = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int NBYTE = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CSn,
  input  logic              RASn,
  input  logic              CASn,
  input  logic [NBYTE-1:0]  WEn,
  input  logic [BA_W-1:0]   BA,
  input  logic [ROW_W-1:0]  A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q,
  output logic              VALID,
  output logic              err
);

  localparam int NB     = 2 ** BA_W;
  localparam int MEM_AW = ((BANKS > 1) ? BA_W : 0) + ROW_W + COL_W;

  cmd_e                  cmd;
  logic [BA_W-1:0]       bank_sel;
  logic [NB-1:0]         bank_legal;
  logic [NB-1:0][ROW_W-1:0] bank_row;
  logic                  legal, wr_go, rd_go;
  logic [MEM_AW-1:0]     mem_addr;
  logic [DATA_W-1:0]     rd_word;

  logic [DATA_W-1:0]     mem [0:2**MEM_AW-1];

  assign cmd      = decode_cmd(CSn, RASn, CASn, &WEn);
  assign bank_sel = (BANKS > 1) ? BA : '0;

  // Arrays are padded to a power of two so bank_sel indexes them exactly;
  // padding slots are never selected.
  for (genvar b = 0; b < NB; b++) begin : g_bank
    if (b < BANKS) begin : g_real
      dram_bank_fsm #(.ROW_W(ROW_W), .T_RCD(T_RCD), .T_RP(T_RP)) u_bank (
        .clk      (clk),
        .rst      (rst),
        .sel      (bank_sel == BA_W'(b)),
        .cmd      (cmd),
        .row      (A),
        .legal    (bank_legal[b]),
        .open_row (bank_row[b])
      );
    end else begin : g_pad
      assign bank_legal[b] = 1'b0;
      assign bank_row[b]   = '0;
    end
  end

  assign legal    = bank_legal[bank_sel];
  assign wr_go    = (cmd == WRITE) && legal;
  assign rd_go    = (cmd == READ)  && legal;
  // With one bank the bank bit is always 0 and drops out of the address.
  assign mem_addr = MEM_AW'({bank_sel, bank_row[bank_sel], A[COL_W-1:0]});
  assign rd_word  = mem[mem_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          err <= 1'b0;
    else if (cmd != NOP && !legal)    err <= 1'b1;
  end

  // Memory has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_go)
      for (int i = 0; i < NBYTE; i++)
        if (!WEn[i]) mem[mem_addr][i*8 +: 8] <= D[i*8 +: 8];
  end

  // Read pipeline: the word is captured at issue so later writes cannot
  // disturb it. Each stage only loads when valid, so the last stage (Q)
  // holds its value between strobes.
  logic [T_CL:1]     vld_pipe;
  logic [DATA_W-1:0] dat_pipe [1:T_CL];

  for (genvar s = 1; s <= T_CL; s++) begin : g_rd
    logic              v_in;
    logic [DATA_W-1:0] d_in;
    if (s == 1) begin : g_head
      assign v_in = rd_go;
      assign d_in = rd_word;
    end else begin : g_body
      assign v_in = vld_pipe[s-1];
      assign d_in = dat_pipe[s-1];
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_pipe[s] <= 1'b0;
        dat_pipe[s] <= '0;
      end else begin
        vld_pipe[s] <= v_in;
        if (v_in) dat_pipe[s] <= d_in;
      end
    end
  end

  assign VALID = vld_pipe[T_CL];
  assign Q     = dat_pipe[T_CL];

endmodule

// File: tb/tb_dram_model_mb.sv
// Directed bench: d1 is the single-bank default model, d4 a 4-bank model.
// Inputs change on the falling edge; outputs are sampled on the falling
// edge, i.e. the value the model presents to the next rising edge.
module tb_dram_model_mb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CSn1, CSn4, RASn, CASn;
  logic [3:0]  WEn;
  logic [1:0]  BA;
  logic [10:0] A;
  logic [31:0] D;
  logic [31:0] Q1, Q4;
  logic        VALID1, VALID4, err1, err4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dram_model_mb d1 (
    .clk(clk), .rst(rst), .CSn(CSn1), .RASn(RASn), .CASn(CASn), .WEn(WEn),
    .BA(BA[0:0]), .A(A), .D(D), .Q(Q1), .VALID(VALID1), .err(err1)
  );

  dram_model_mb #(.BANKS(4), .ROW_W(8), .COL_W(6)) d4 (
    .clk(clk), .rst(rst), .CSn(CSn4), .RASn(RASn), .CASn(CASn), .WEn(WEn),
    .BA(BA), .A(A[7:0]), .D(D), .Q(Q4), .VALID(VALID4), .err(err4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_pins();
    CSn1 = 1'b1; CSn4 = 1'b1; RASn = 1'b1; CASn = 1'b1;
    WEn = 4'hF; BA = '0; A = '0; D = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input int tgt, input logic ras, input logic cas, input logic [3:0] we,
                       input logic [1:0] ba, input logic [10:0] a, input logic [31:0] d);
    if (tgt == 1) CSn1 = 1'b0; else CSn4 = 1'b0;
    RASn = ras; CASn = cas; WEn = we; BA = ba; A = a; D = d;
    tick();
    idle_pins();
  endtask

  task automatic act(input int t, input logic [1:0] ba, input logic [10:0] row);
    issue(t, 1'b0, 1'b1, 4'hF, ba, row, 32'h0);
  endtask
  task automatic rd(input int t, input logic [1:0] ba, input logic [10:0] col);
    issue(t, 1'b1, 1'b0, 4'hF, ba, col, 32'h0);
  endtask
  task automatic wr(input int t, input logic [1:0] ba, input logic [10:0] col,
                    input logic [3:0] we, input logic [31:0] d);
    issue(t, 1'b1, 1'b0, we, ba, col, d);
  endtask
  task automatic pre(input int t, input logic [1:0] ba);
    issue(t, 1'b0, 1'b0, 4'hF, ba, 11'h0, 32'h0);
  endtask

  // READ on d1, then expect exactly one VALID strobe 5 cycles after issue.
  task automatic rd_check(input logic [10:0] col, input logic [31:0] exp, input string tag);
    rd(1, 2'd0, col);
    check({tag, "_v0"}, VALID1, 1'b0);
    for (int j = 1; j <= 4; j++) begin
      tick();
      if (j < 4) check({tag, "_vwait"}, VALID1, 1'b0);
      else begin
        check({tag, "_valid"}, VALID1, 1'b1);
        check({tag, "_q"}, Q1, exp);
      end
    end
    tick();
    check({tag, "_vdrop"}, VALID1, 1'b0);
    check({tag, "_qhold"}, Q1, exp);
  endtask

  logic [31:0] exp4 [4];

  initial begin
    idle_pins();
    #12;
    check("rst_valid1", VALID1, 1'b0);
    check("rst_q1",     Q1,     32'h0);
    check("rst_err1",   err1,   1'b0);
    check("rst_valid4", VALID4, 1'b0);
    check("rst_q4",     Q4,     32'h0);
    check("rst_err4",   err4,   1'b0);
    @(negedge clk);
    rst = 1'b0;

    // ACT row 3 at cycle 0, WRITE at cycle 5 (first legal), READ at 6.
    act(1, 2'd0, 11'd3);
    nop(4);
    wr(1, 2'd0, 11'd7, 4'h0, 32'hDEADBEEF);
    check("wr_trcd_err", err1, 1'b0);
    rd_check(11'd7, 32'hDEADBEEF, "basic");

    // Only byte 1 enabled.
    wr(1, 2'd0, 11'd7, 4'b1101, 32'h11223344);
    rd_check(11'd7, 32'hDEAD33EF, "bytewr");

    // READ then WRITE to the same word: pending read keeps the old value.
    rd(1, 2'd0, 11'd7);
    wr(1, 2'd0, 11'd7, 4'h0, 32'hCAFEF00D);
    check("raw_v1", VALID1, 1'b0);
    nop(2);
    check("raw_v3", VALID1, 1'b0);
    tick();
    check("raw_valid", VALID1, 1'b1);
    check("raw_old",   Q1,     32'hDEAD33EF);
    rd_check(11'd7, 32'hCAFEF00D, "raw_new");

    // PRE -> ACT after T_RP, then a READ one cycle too early.
    pre(1, 2'd0);
    nop(4);
    act(1, 2'd0, 11'd3);
    check("trp_err", err1, 1'b0);
    nop(3);
    rd(1, 2'd0, 11'd7);
    check("early_rd_err", err1, 1'b1);
    for (int j = 0; j < 6; j++) begin
      check("early_rd_novalid", VALID1, 1'b0);
      tick();
    end
    check("early_rd_qhold", Q1, 32'hCAFEF00D);
    // WRITE while CLOSING is illegal and must not reach memory.
    pre(1, 2'd0);
    wr(1, 2'd0, 11'd7, 4'h0, 32'hBAD0BAD0);
    nop(3);
    act(1, 2'd0, 11'd3);
    nop(4);
    rd_check(11'd7, 32'hCAFEF00D, "illegal_wr");
    check("err_sticky", err1, 1'b1);

    // Reset two cycles after a READ: pipeline dropped, memory kept.
    rd(1, 2'd0, 11'd7);
    nop(2);
    rst = 1'b1;
    #1;
    check("midrst_valid", VALID1, 1'b0);
    check("midrst_q",     Q1,     32'h0);
    check("midrst_err",   err1,   1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      check("postrst_novalid", VALID1, 1'b0);
    end
    act(1, 2'd0, 11'd3);
    nop(4);
    rd_check(11'd7, 32'hCAFEF00D, "persist");

    // Four banks: ACT bank 0 and bank 2 back to back, then interleave.
    act(4, 2'd0, 11'd1);
    act(4, 2'd2, 11'd9);
    check("bank_indep_err", err4, 1'b0);
    nop(3);
    wr(4, 2'd0, 11'd4, 4'h0, 32'hA0A00004);
    wr(4, 2'd2, 11'd4, 4'h0, 32'hB2B20004);
    wr(4, 2'd0, 11'd5, 4'h0, 32'hA0A00005);
    wr(4, 2'd2, 11'd5, 4'h0, 32'hB2B20005);
    check("mb_wr_err", err4, 1'b0);
    exp4[0] = 32'hA0A00004; exp4[1] = 32'hB2B20004;
    exp4[2] = 32'hA0A00005; exp4[3] = 32'hB2B20005;
    rd(4, 2'd0, 11'd4); check("mb_v_issue", VALID4, 1'b0);
    rd(4, 2'd2, 11'd4); check("mb_v_issue", VALID4, 1'b0);
    rd(4, 2'd0, 11'd5); check("mb_v_issue", VALID4, 1'b0);
    rd(4, 2'd2, 11'd5); check("mb_v_issue", VALID4, 1'b0);
    for (int j = 0; j < 4; j++) begin
      tick();
      check("mb_valid", VALID4, 1'b1);
      check("mb_q",     Q4,     exp4[j]);
    end
    tick();
    check("mb_vdrop", VALID4, 1'b0);
    check("mb_err",   err4,   1'b0);
    check("d1_quiet", VALID1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
